// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_pkg
// Brief    : Shared types and constants for the AXI4-Lite to APB bridge and
//            its APB-side register completer.
// Revision : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

  // Bus word types shared by both sides of the bridge
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;

  // APB completer protocol state
  typedef enum logic [0:0] {
    APB_IDLE   = 1'b0,
    APB_ACCESS = 1'b1
  } apb_state_e;

  // Bytes per bus word; also the address stride between buffer words
  localparam int APB_BYTES_PER_WORD = 4;

  // Merge new write data into an existing word, byte lane by byte lane.
  // Lanes whose strobe is low keep their old contents.
  function automatic data_t strb_merge(input data_t old_word,
                                       input data_t new_word,
                                       input strb_t strb);
    data_t merged;
    merged = old_word;
    for (int b = 0; b < APB_BYTES_PER_WORD; b++) begin
      if (strb[b]) begin
        merged[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage : axi_lite_pkg
`default_nettype wire

// File: rtl/apb_reg_buffer.sv
`default_nettype none
// ============================================================================
// Module   : apb_reg_buffer
// Brief    : Word-addressed register storage with a byte-strobed write port,
//            a combinational read port and an asynchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module apb_reg_buffer
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_we,
  input  logic [$clog2(NUM_REGS)-1:0] i_widx,
  input  data_t                       i_wdata,
  input  strb_t                       i_wstrb,
  input  logic [$clog2(NUM_REGS)-1:0] i_ridx,
  output data_t                       o_rdata
);

  // Storage kept under this exact name so benches can peek at it
  data_t buffer [NUM_REGS];

  // Clear every word on reset; otherwise merge strobed bytes into one word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        buffer[i] <= '0;
      end
    end else if (i_we) begin
      buffer[i_widx] <= strb_merge(buffer[i_widx], i_wdata, i_wstrb);
    end
  end

  // Read port is purely combinational; the completer decides when to use it
  assign o_rdata = buffer[i_ridx];

endmodule : apb_reg_buffer
`default_nettype wire

// File: rtl/apb_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave
// Brief    : APB4 completer backed by a word-addressed register buffer, with
//            a fixed number of wait states, byte strobes and SLVERR on
//            misaligned or out-of-range addresses.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic  aclk,
  input  logic  areset_n,
  input  logic  psel,
  input  logic  penable,
  input  logic  pwrite,
  input  addr_t paddr,
  input  data_t pwdata,
  input  strb_t pstrb,
  output data_t prdata,
  output logic  pready,
  output logic  pslverr
);

  localparam int             IDX_W        = $clog2(NUM_REGS);
  localparam int             CNT_W        = 4;
  localparam logic [CNT_W-1:0] C_WAIT_INIT  = CNT_W'(WAIT_STATES);
  localparam addr_t          C_ADDR_LIMIT = addr_t'(NUM_REGS * APB_BYTES_PER_WORD);

  // Protocol state and wait-state counter
  apb_state_e        r_state;
  apb_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]  w_wait_cnt_nxt;

  // Last completed read value, and the address-error flag sampled one cycle
  // earlier so pslverr never depends combinationally on the live bus
  data_t             r_prdata;
  logic              r_addr_err;

  // Decode and datapath wires
  logic              w_setup;
  logic              w_xfer_live;
  logic              w_complete;
  logic              w_bad_addr;
  logic [IDX_W-1:0]  w_idx;
  logic              w_we;
  logic              w_rd_done;
  data_t             w_rdata;
  data_t             w_rd_value;

  // Bus qualifiers
  assign w_setup     = psel && !penable;
  assign w_xfer_live = psel && penable;

  // The completing cycle is fully determined by registered state
  assign w_complete  = (r_state == APB_ACCESS) && (r_wait_cnt == '0);

  // Misaligned or beyond the end of the buffer
  assign w_bad_addr  = (paddr[1:0] != 2'b00) || (paddr >= C_ADDR_LIMIT);
  assign w_idx       = paddr[IDX_W+1:2];

  // State register and wait counter; reset drops any transfer in flight
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state    <= APB_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Next-state and counter logic
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      APB_IDLE: begin
        if (w_setup) begin
          w_state_nxt    = APB_ACCESS;
          w_wait_cnt_nxt = C_WAIT_INIT;
        end
      end
      APB_ACCESS: begin
        if (!w_xfer_live) begin
          // Requester abandoned the transfer
          w_state_nxt = APB_IDLE;
        end else if (r_wait_cnt != '0) begin
          w_wait_cnt_nxt = r_wait_cnt - 1'b1;
        end else begin
          w_state_nxt = APB_IDLE;
        end
      end
      default: begin
        w_state_nxt    = APB_IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode: handshake from registered state, data from the buffer
  always_comb begin
    pready     = w_complete;
    pslverr    = w_complete && r_addr_err;
    w_we       = w_complete && w_xfer_live && pwrite && !w_bad_addr;
    w_rd_done  = w_complete && w_xfer_live && !pwrite;
    w_rd_value = w_bad_addr ? '0 : w_rdata;
    prdata     = w_rd_done ? w_rd_value : r_prdata;
  end

  // Hold the last read result and track the address-error flag. Under APB
  // paddr is stable from SETUP through completion, so the value sampled on
  // the previous edge matches the live decode in the completing cycle.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_prdata   <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_bad_addr;
      if (w_rd_done) begin
        r_prdata <= w_rd_value;
      end
    end
  end

  // Register storage
  apb_reg_buffer #(
    .NUM_REGS (NUM_REGS)
  ) u_buf (
    .clk     (aclk),
    .rst_n   (areset_n),
    .i_we    (w_we),
    .i_widx  (w_idx),
    .i_wdata (pwdata),
    .i_wstrb (pstrb),
    .i_ridx  (w_idx),
    .o_rdata (w_rdata)
  );

endmodule : apb_slave
`default_nettype wire

// File: tb/tb_apb_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave
// Brief    : Scoreboard bench for apb_slave. Three instances with different
//            wait-state settings share one APB bus; psel picks the target.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave;
  import axi_lite_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] psel    = '0;
  logic       penable = 1'b0;
  logic       pwrite  = 1'b0;
  addr_t      paddr   = '0;
  data_t      pwdata  = '0;
  strb_t      pstrb   = '0;
  data_t      prdata [3];
  logic [2:0] pready;
  logic [2:0] pslverr;

  // Instance 0: no wait states
  apb_slave #(.NUM_REGS(32), .WAIT_STATES(0)) dut0 (
    .aclk(clk), .areset_n(rst_n), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

  // Instance 1: three wait states
  apb_slave #(.NUM_REGS(32), .WAIT_STATES(3)) dut1 (
    .aclk(clk), .areset_n(rst_n), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

  // Instance 2: two wait states
  apb_slave #(.NUM_REGS(32), .WAIT_STATES(2)) dut2 (
    .aclk(clk), .areset_n(rst_n), .psel(psel[2]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]));

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    dut;
    int    cyc;
    bit    is_rd;
    data_t rdata;
    bit    err;
  } exp_t;

  exp_t sb[$];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: whenever a target completes, pop the oldest expectation
  exp_t m_e;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (pready[i] === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pready: dut%0d completed at cycle %0d with nothing expected", i, cyc);
          end else begin
            m_e = sb.pop_front();
            check("completing_dut", i, m_e.dut);
            check("completion_cycle", cyc, m_e.cyc);
            check("pslverr", {31'd0, pslverr[i]}, {31'd0, m_e.err});
            if (m_e.is_rd) check("prdata", prdata[i], m_e.rdata);
          end
        end else if (pslverr[i] !== 1'b0) begin
          checks++;
          errors++;
          $display("FAIL pslverr_without_pready: dut%0d got %b expected 0", i, pslverr[i]);
        end
      end
    end
  end

  // One transfer; called just after a rising edge, returns on the completing edge
  task automatic xfer(input int d, input bit wr, input addr_t a, input data_t wd,
                      input strb_t st, input bit exp_err, input data_t exp_rd);
    exp_t e;
    int   n;
    #1;
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    pstrb   = st;
    e.dut   = d;
    e.cyc   = cyc + ws_of(d) + 1;
    e.is_rd = !wr;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1 penable = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (pready[d] === 1'b1) break;
      n++;
      if (n >= 40) begin
        checks++;
        errors++;
        $display("FAIL pready_timeout: dut%0d addr %h got no pready expected one", d, a);
        break;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle();
    #1;
    psel    = '0;
    penable = 1'b0;
    @(posedge clk);
  endtask

  data_t exp_word;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("reset_pready", {29'd0, pready}, 32'd0);
    check("reset_pslverr", {29'd0, pslverr}, 32'd0);
    check("reset_prdata0", prdata[0], 32'd0);
    check("reset_buffer1", dut0.u_buf.buffer[1], 32'd0);
    rst_n = 1'b1;
    @(posedge clk);

    // Full write then read, no wait states
    xfer(0, 1'b1, 32'h4, 32'hdeadbeef, 4'b1111, 1'b0, 32'h0);
    idle();
    #2 check("buffer1_after_write", dut0.u_buf.buffer[1], 32'hdeadbeef);
    @(posedge clk);
    xfer(0, 1'b0, 32'h4, 32'h0, 4'b0000, 1'b0, 32'hdeadbeef);
    idle();

    // Partial strobe, then back-to-back read with pstrb ignored
    xfer(0, 1'b1, 32'h4, 32'h12345678, 4'b0011, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h4, 32'h0, 4'b1111, 1'b0, 32'hdead5678);
    idle();
    #2 check("prdata_hold", prdata[0], 32'hdead5678);
    @(posedge clk);

    // Empty strobe leaves the word alone
    xfer(0, 1'b1, 32'h4, 32'hffffffff, 4'b0000, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h4, 32'h0, 4'b0000, 1'b0, 32'hdead5678);

    // Highest word
    xfer(0, 1'b1, 32'h7c, 32'h0badf00d, 4'b1111, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h7c, 32'h0, 4'b0000, 1'b0, 32'h0badf00d);

    // Out-of-range and misaligned writes are errored and change nothing
    xfer(0, 1'b1, 32'h80, 32'hffffffff, 4'b1111, 1'b1, 32'h0);
    xfer(0, 1'b1, 32'h6, 32'hffffffff, 4'b1111, 1'b1, 32'h0);
    idle();
    #2;
    for (int i = 0; i < 32; i++) begin
      exp_word = (i == 1) ? 32'hdead5678 : (i == 31) ? 32'h0badf00d : 32'h0;
      check($sformatf("buffer%0d_after_err", i), dut0.u_buf.buffer[i], exp_word);
    end
    @(posedge clk);
    xfer(0, 1'b0, 32'h80, 32'h0, 4'b0000, 1'b1, 32'h0);
    xfer(0, 1'b0, 32'h5, 32'h0, 4'b0000, 1'b1, 32'h0);
    idle();

    // Three wait states, including back-to-back reads
    xfer(1, 1'b1, 32'h0, 32'hcafef00d, 4'b1111, 1'b0, 32'h0);
    xfer(1, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'hcafef00d);
    xfer(1, 1'b0, 32'h4, 32'h0, 4'b0000, 1'b0, 32'h0);
    idle();

    // Two wait states: set up a known word and read value
    xfer(2, 1'b1, 32'h8, 32'h11112222, 4'b1111, 1'b0, 32'h0);
    xfer(2, 1'b0, 32'h8, 32'h0, 4'b0000, 1'b0, 32'h11112222);
    idle();

    // Abort: penable dropped in the second ACCESS cycle
    #1;
    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h8;
    pwdata  = 32'ha5a5a5a5;
    pstrb   = 4'b1111;
    @(posedge clk);
    #1 penable = 1'b1;
    @(posedge clk);
    #1 penable = 1'b0;
    @(posedge clk);
    #1 psel = '0;
    repeat (4) @(posedge clk);
    #2 check("buffer2_after_abort", dut2.u_buf.buffer[2], 32'h11112222);
    @(posedge clk);

    // Reset in the middle of a waiting write
    #1;
    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h8;
    pwdata  = 32'h55555555;
    pstrb   = 4'b1111;
    @(posedge clk);
    #1 penable = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_pready", {29'd0, pready}, 32'd0);
    check("midreset_pslverr", {29'd0, pslverr}, 32'd0);
    check("midreset_prdata2", prdata[2], 32'd0);
    check("midreset_buffer2", dut2.u_buf.buffer[2], 32'd0);
    check("midreset_dut0_buffer1", dut0.u_buf.buffer[1], 32'd0);
    psel    = '0;
    penable = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 check("buffer2_after_reset", dut2.u_buf.buffer[2], 32'd0);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_apb_slave
`default_nettype wire
